// File: rtl/demux_byte_collector_if.sv
// Bit-side inputs from the 1:4 demux plus the word-side valid/ready port of demux_byte_collector.
// The collector connects to the slave modport; its driver or consumer connects to master.
interface demux_byte_collector_if #(
  parameter int WIDTH = 8
);
  logic             bit_valid;
  logic [1:0]       s;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_chan;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       overflow;
  logic             clr_ovf;

  modport master (
    output bit_valid, s, a, b, c, d, out_ready, clr_ovf,
    input  out_valid, out_chan, out_data, overflow
  );

  modport slave (
    input  bit_valid, s, a, b, c, d, out_ready, clr_ovf,
    output out_valid, out_chan, out_data, overflow
  );
endinterface

// File: rtl/demux_byte_collector.sv
// Deserialises four demux lines into WIDTH-bit words and hands them out round-robin; final bit -> out_valid is 2 edges.
// Bit capture is never stalled: a word completing on a still-full, ungranted hold slot is dropped and flagged in overflow.
module demux_byte_collector #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  demux_byte_collector_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt [4];
  logic [WIDTH-2:0] sh [4];
  logic [WIDTH-1:0] hold [4];
  logic [3:0]       hold_full;
  logic [1:0]       last_grant;

  logic             out_valid_q;
  logic [1:0]       out_chan_q;
  logic [WIDTH-1:0] out_data_q;
  logic [3:0]       overflow_q;

  logic             sel_bit;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             word_drop;
  logic [3:0]       ovf_set;
  logic             out_load;
  logic             gnt_vld;
  logic [1:0]       gnt_ch;
  logic [1:0]       cand;

  // Only the selected channel's line carries data; the other three are don't-care.
  always_comb begin
    sel_bit = 1'b0;
    case (bus.s)
      2'd0:    sel_bit = bus.a;
      2'd1:    sel_bit = bus.b;
      2'd2:    sel_bit = bus.c;
      default: sel_bit = bus.d;
    endcase
  end

  assign word      = {sh[bus.s], sel_bit};
  assign word_done = bus.bit_valid && (cnt[bus.s] == CW'(WIDTH - 1));
  assign out_load  = !out_valid_q || bus.out_ready;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = 2'd0;
    cand    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!gnt_vld && hold_full[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
    if (!out_load) begin
      gnt_vld = 1'b0;
    end
  end

  // A slot being emptied by this edge's grant can take the new word without loss.
  assign word_drop = word_done && hold_full[bus.s] && !(gnt_vld && (gnt_ch == bus.s));
  assign ovf_set   = word_drop ? (4'b0001 << bus.s) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
        sh[i]  <= '0;
      end
    end else if (bus.bit_valid) begin
      sh[bus.s]  <= word[WIDTH-2:0];
      cnt[bus.s] <= word_done ? '0 : cnt[bus.s] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        hold[i] <= '0;
      end
      hold_full   <= 4'b0000;
      last_grant  <= 2'd3;
      out_valid_q <= 1'b0;
      out_chan_q  <= 2'd0;
      out_data_q  <= '0;
      overflow_q  <= 4'b0000;
    end else begin
      if (gnt_vld) begin
        hold_full[gnt_ch] <= 1'b0;
        last_grant        <= gnt_ch;
      end
      if (word_done && !word_drop) begin
        hold[bus.s]      <= word;
        hold_full[bus.s] <= 1'b1;
      end
      if (out_load) begin
        out_valid_q <= gnt_vld;
        if (gnt_vld) begin
          out_chan_q <= gnt_ch;
          out_data_q <= hold[gnt_ch];
        end
      end
      overflow_q <= (bus.clr_ovf ? 4'b0000 : overflow_q) | ovf_set;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_demux_byte_collector.sv
// Directed and random stimulus for demux_byte_collector, checked every cycle against a queue-based reference model.
module tb_demux_byte_collector;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  demux_byte_collector_if #(.WIDTH(W)) bus ();
  demux_byte_collector #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-channel bit queues, one pending word per channel, one output slot.
  bit           m_q [4][$];
  logic [W-1:0] m_hold [4];
  bit           m_full [4];
  int           m_last;
  bit           m_val;
  int           m_chan;
  logic [W-1:0] m_data;
  logic [3:0]   m_ov;

  logic         prev_val;
  logic [1:0]   prev_chan;
  logic [W-1:0] prev_data;
  logic [1:0]   acc_chan [$];
  logic [W-1:0] acc_data [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_q[i].delete();
      m_hold[i] = '0;
      m_full[i] = 1'b0;
    end
    m_last = 3;
    m_val  = 1'b0;
    m_chan = 0;
    m_data = '0;
    m_ov   = 4'b0;
    prev_val = 1'b0;
  endfunction

  function automatic void model_edge();
    bit           load;
    int           g;
    int           ch;
    bit           bv;
    logic [3:0]   set;
    logic [W-1:0] w;
    load = !m_val || bus.out_ready;
    g    = -1;
    set  = 4'b0;
    if (load) begin
      for (int k = 1; k <= 4; k++)
        if (g < 0 && m_full[(m_last + k) % 4]) g = (m_last + k) % 4;
      if (g >= 0) begin
        m_val = 1'b1; m_chan = g; m_data = m_hold[g]; m_full[g] = 1'b0; m_last = g;
      end else begin
        m_val = 1'b0;
      end
    end
    if (bus.bit_valid) begin
      ch = int'(bus.s);
      bv = (ch == 0) ? bus.a : (ch == 1) ? bus.b : (ch == 2) ? bus.c : bus.d;
      m_q[ch].push_back(bv);
      if (m_q[ch].size() == W) begin
        w = '0;
        for (int i = 0; i < W; i++) w = {w[W-2:0], m_q[ch][i]};
        m_q[ch].delete();
        if (m_full[ch]) set[ch] = 1'b1;
        else begin
          m_hold[ch] = w;
          m_full[ch] = 1'b1;
        end
      end
    end
    m_ov = (bus.clr_ovf ? 4'b0 : m_ov) | set;
  endfunction

  task automatic step();
    if (prev_val && bus.out_ready) begin
      acc_chan.push_back(prev_chan);
      acc_data.push_back(prev_data);
    end
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk("out_valid", bus.out_valid, m_val);
    if (m_val) begin
      chk("out_chan", bus.out_chan, m_chan);
      chk("out_data", bus.out_data, m_data);
    end
    chk("overflow", bus.overflow, m_ov);
    prev_val  = bus.out_valid;
    prev_chan = bus.out_chan;
    prev_data = bus.out_data;
  endtask

  task automatic drive(input bit bv, input int ch, input bit v, input bit rdy);
    {bus.a, bus.b, bus.c, bus.d} = 4'($urandom);
    bus.bit_valid = bv;
    bus.s         = 2'(ch);
    bus.out_ready = rdy;
    bus.clr_ovf   = 1'b0;
    if (bv) begin
      case (ch)
        0:       bus.a = v;
        1:       bus.b = v;
        2:       bus.c = v;
        default: bus.d = v;
      endcase
    end
  endtask

  task automatic send_word(input int ch, input logic [W-1:0] w, input bit rdy);
    for (int i = W - 1; i >= 0; i--) begin
      drive(1'b1, ch, w[i], rdy);
      step();
    end
  endtask

  task automatic idle(input bit rdy, input int n);
    repeat (n) begin
      drive(1'b0, int'($urandom_range(3)), 1'b0, rdy);
      step();
    end
  endtask

  task automatic clear_log();
    acc_chan.delete();
    acc_data.delete();
  endtask

  task automatic chk_log(input string tag, input int idx, input int ch, input logic [W-1:0] data);
    if (idx < acc_chan.size()) begin
      chk({tag, "_chan"}, acc_chan[idx], ch);
      chk({tag, "_data"}, acc_data[idx], data);
    end else begin
      chk({tag, "_count"}, acc_chan.size(), idx + 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_chan"}, bus.out_chan, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
  endtask

  logic [W-1:0] rr_w [4];
  logic [W-1:0] w5a;

  initial begin
    bus.bit_valid = 1'b0; bus.s = 2'd0;
    bus.a = 1'b0; bus.b = 1'b0; bus.c = 1'b0; bus.d = 1'b0;
    bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-stream while a word is presented.
    send_word(0, 8'hC6, 1'b0);
    idle(1'b0, 1);
    chk("pre_rst_valid", bus.out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1, 1'($urandom), 1'b0);
      step();
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    model_reset();
    clear_log();
    @(negedge clk);
    rst_n = 1'b1;

    send_word(2, 8'hA5, 1'b0);
    chk("a5_not_yet", bus.out_valid, 0);
    idle(1'b0, 1);
    chk("a5_valid", bus.out_valid, 1);
    chk("a5_chan", bus.out_chan, 2);
    chk("a5_data", bus.out_data, 8'hA5);
    idle(1'b1, 3);

    // Interleaved channels 0 and 1.
    clear_log();
    for (int i = 0; i < W; i++) begin
      drive(1'b1, 0, 1'b1, 1'b1); step();
      drive(1'b1, 1, 1'b0, 1'b1); step();
    end
    idle(1'b1, 3);
    chk_log("ilv0", 0, 0, 8'hFF);
    chk_log("ilv1", 1, 1, 8'h00);
    chk("ilv_ovf", bus.overflow, 0);

    // Unselected lines toggle and bit_valid gaps are inserted.
    clear_log();
    for (int i = W - 1; i >= 0; i--) begin
      if ($urandom_range(1) == 1) idle(1'b1, int'($urandom_range(1, 2)));
      drive(1'b1, 0, w5a_bit(8'h3C, i), 1'b1);
      step();
    end
    idle(1'b1, 3);
    chk_log("gap", 0, 0, 8'h3C);

    // Round-robin: four words complete on consecutive edges while blocked.
    clear_log();
    rr_w[0] = 8'h10; rr_w[1] = 8'h21; rr_w[2] = 8'h42; rr_w[3] = 8'h83;
    for (int ch = 0; ch < 4; ch++)
      for (int i = W - 1; i >= 1; i--) begin
        drive(1'b1, ch, rr_w[ch][i], 1'b0);
        step();
      end
    for (int ch = 0; ch < 4; ch++) begin
      drive(1'b1, ch, rr_w[ch][0], 1'b0);
      step();
    end
    idle(1'b1, 6);
    for (int i = 0; i < 4; i++) chk_log("rr", i, i, rr_w[i]);

    clear_log();
    send_word(1, 8'h77, 1'b0);
    send_word(3, 8'h99, 1'b0);
    send_word(2, 8'h55, 1'b0);
    idle(1'b1, 5);
    chk_log("rr2_a", 0, 1, 8'h77);
    chk_log("rr2_b", 1, 2, 8'h55);
    chk_log("rr2_c", 2, 3, 8'h99);

    // Overflow on channel 1, then clear.
    clear_log();
    send_word(1, 8'h11, 1'b0);
    send_word(1, 8'h22, 1'b0);
    send_word(1, 8'h33, 1'b0);
    chk("ovf_held_valid", bus.out_valid, 1);
    chk("ovf_held_data", bus.out_data, 8'h11);
    chk("ovf_flag", bus.overflow, 4'b0010);
    drive(1'b0, 0, 1'b0, 1'b0);
    bus.clr_ovf = 1'b1;
    step();
    chk("ovf_cleared", bus.overflow, 0);
    idle(1'b1, 4);
    chk_log("ovf_a", 0, 1, 8'h11);
    chk_log("ovf_b", 1, 1, 8'h22);
    chk("ovf_count", acc_chan.size(), 2);

    // Channel 3 hold granted on the same edge its next word completes.
    clear_log();
    w5a = 8'h5A;
    send_word(3, 8'hC3, 1'b0);
    send_word(3, 8'h7E, 1'b0);
    for (int i = W - 1; i >= 1; i--) begin
      drive(1'b1, 3, w5a[i], 1'b0);
      step();
    end
    drive(1'b1, 3, w5a[0], 1'b1);
    step();
    chk("sim_ovf", bus.overflow, 0);
    idle(1'b1, 4);
    chk_log("sim_a", 0, 3, 8'hC3);
    chk_log("sim_b", 1, 3, 8'h7E);
    chk_log("sim_c", 2, 3, 8'h5A);

    // Random traffic against the model.
    repeat (400) begin
      drive($urandom_range(3) != 0, int'($urandom_range(3)), 1'($urandom), $urandom_range(9) < 7);
      if ($urandom_range(15) == 0) bus.clr_ovf = 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic bit w5a_bit(input logic [W-1:0] w, input int i);
    return w[i];
  endfunction
endmodule
